// File: rtl/stim_sequencer.sv
// Stimulus sequencer: replays {rst, in} words from on-chip RAM onto a DUT,
// with programmable length, per-vector hold, repeat count, pause and stop.
module stim_sequencer #(
  parameter int IN_W   = 7,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int HOLD_W = 8,
  parameter int REP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [IN_W:0]     wr_data,
  input  logic [ADDR_W:0]   seq_len,
  input  logic [HOLD_W-1:0] hold,
  input  logic [REP_W-1:0]  reps,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic              dut_rst,
  output logic [IN_W-1:0]   dut_in,
  output logic [ADDR_W-1:0] vec_idx,
  output logic [REP_W-1:0]  pass_idx,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_PAUSE, S_DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [REP_W-1:0]  PASS_ONE = REP_W'(1);
  localparam logic [IN_W:0]     OUT_RST  = {1'b1, {IN_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [HOLD_W-1:0] hold_m1_q, hold_m1_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0]  reps_q, reps_d;
  logic [REP_W-1:0]  pass_q, pass_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              first_q, first_d;
  logic [IN_W:0]     out_q, out_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              wr_err_q, wr_err_d;

  logic [IN_W:0]     mem [DEPTH];
  logic [IN_W:0]     rd_data_q;
  logic [ADDR_W-1:0] raddr;
  logic              wr_ok;

  logic [ADDR_W:0]   len_m1;
  logic              cur_last, nxt_last, final_pass;
  logic [ADDR_W-1:0] nxt_inc;
  logic [REP_W-1:0]  pass_inc;

  assign len_m1     = len_q - LEN_ONE;
  assign cur_last   = ({1'b0, vec_q} == len_m1);
  assign nxt_last   = ({1'b0, nxt_q} == len_m1);
  assign nxt_inc    = nxt_last ? '0 : nxt_q + ADDR_ONE;
  assign pass_inc   = pass_q + PASS_ONE;
  assign final_pass = (reps_q != '0) && (pass_inc == reps_q);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    hold_m1_d = hold_m1_q;
    reps_d    = reps_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    nxt_d     = nxt_q;
    vec_d     = vec_q;
    first_d   = first_q;
    out_d     = out_q;
    done_d    = 1'b0;
    raddr     = nxt_q;
    wr_ok     = wr_en && !busy_q && ({1'b0, wr_addr} < DEPTH_L);
    wr_err_d  = wr_en && !wr_ok;

    if (stop) begin
      state_d = S_IDLE;
      out_d   = OUT_RST;
      vec_d   = '0;
      pass_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_d     = seq_len;
            hold_m1_d = (hold == '0) ? '0 : hold - HOLD_ONE;
            reps_d    = reps;
            pass_d    = '0;
            if (seq_len == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_FETCH;
              nxt_d   = '0;
              first_d = 1'b1;
            end
          end
        end
        S_FETCH: begin
          state_d = S_PLAY;
          cnt_d   = '0;
        end
        S_PLAY, S_PAUSE: begin
          if (pause) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_PLAY;
            if (cnt_q != '0) begin
              cnt_d  = cnt_q - HOLD_ONE;
              done_d = (cnt_d == '0) && cur_last && final_pass;
            end else if (!first_q && cur_last && final_pass) begin
              state_d = S_DONE;
              pass_d  = pass_inc;
            end else begin
              // rd_data_q already holds vector nxt_q; fetch the one after it now
              out_d   = rd_data_q;
              vec_d   = nxt_q;
              nxt_d   = nxt_inc;
              raddr   = nxt_inc;
              cnt_d   = hold_m1_q;
              first_d = 1'b0;
              if (!first_q && cur_last) pass_d = pass_inc;
              done_d  = (hold_m1_q == '0) && nxt_last && (reps_q != '0) &&
                        ((pass_d + PASS_ONE) == reps_q);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_PLAY) || (state_d == S_PAUSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      hold_m1_q <= '0;
      reps_q    <= '0;
      cnt_q     <= '0;
      pass_q    <= '0;
      nxt_q     <= '0;
      vec_q     <= '0;
      first_q   <= 1'b0;
      out_q     <= OUT_RST;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      hold_m1_q <= hold_m1_d;
      reps_q    <= reps_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      nxt_q     <= nxt_d;
      vec_q     <= vec_d;
      first_q   <= first_d;
      out_q     <= out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Vector RAM survives reset; only written while idle.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[raddr];
  end

  assign dut_rst  = out_q[IN_W];
  assign dut_in   = out_q[IN_W-1:0];
  assign vec_idx  = vec_q;
  assign pass_idx = pass_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: directed scenarios plus randomized runs checked
// against a cycle-position model (vector = position / hold mod length).
module tb_stim_sequencer;

  localparam int IN_W   = 7;
  localparam int DEPTH  = 24;
  localparam int ADDR_W = 5;
  localparam int HOLD_W = 8;
  localparam int REP_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [IN_W:0]     wr_data;
  logic [ADDR_W:0]   seq_len;
  logic [HOLD_W-1:0] hold;
  logic [REP_W-1:0]  reps;
  logic              start, stop, pause;
  logic              dut_rst;
  logic [IN_W-1:0]   dut_in;
  logic [ADDR_W-1:0] vec_idx;
  logic [REP_W-1:0]  pass_idx;
  logic              busy, done, wr_err;

  always #5 clk = ~clk;

  stim_sequencer #(
    .IN_W(IN_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_W(HOLD_W), .REP_W(REP_W)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq_len(seq_len), .hold(hold), .reps(reps), .start(start), .stop(stop),
    .pause(pause), .dut_rst(dut_rst), .dut_in(dut_in), .vec_idx(vec_idx),
    .pass_idx(pass_idx), .busy(busy), .done(done), .wr_err(wr_err)
  );

  logic [IN_W:0] ref_mem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [IN_W:0] d, input bit ok);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (ok) ref_mem[a] = d;
    check_eq("wr_err", 32'(wr_err), ok ? 0 : 1);
  endtask

  task automatic check_idle_reset(input string tag);
    check_eq({tag, "_word"}, 32'({dut_rst, dut_in}), 32'h80);
    check_eq({tag, "_vec"}, 32'(vec_idx), 0);
    check_eq({tag, "_pass"}, 32'(pass_idx), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
  endtask

  // Start a run and check ncyc cycles after the fetch stage. pause is driven
  // either randomly or for pz_n cycles starting at loop index pz_at.
  task automatic play(input int len, input int hld, input int rp, input int ncyc,
                      input int pz_at, input int pz_n, input bit rnd_pz,
                      output int vis1);
    int h, total, prog, j, v, ep, eb, ed;
    bit pz;
    h     = (hld == 0) ? 1 : hld;
    total = len * h * rp;
    prog  = 0;
    vis1  = 0;
    seq_len = (ADDR_W+1)'(len);
    hold    = HOLD_W'(hld);
    reps    = REP_W'(rp);
    start   = 1'b1;
    tick();
    start = 1'b0;
    check_eq("fetch_busy", 32'(busy), 1);
    check_eq("fetch_pass", 32'(pass_idx), 0);
    tick();
    check_eq("fetch2_busy", 32'(busy), 1);
    for (int t = 0; t < ncyc; t++) begin
      pz = rnd_pz ? ($urandom_range(0, 3) == 0) : (t >= pz_at && t < pz_at + pz_n);
      pause = pz;
      tick();
      if (!pz) prog++;
      if (prog == 0) begin
        check_eq("pre_busy", 32'(busy), 1);
        check_eq("pre_done", 32'(done), 0);
      end else begin
        j = prog - 1;
        if (rp != 0 && j >= total) begin
          v = len - 1; ep = rp; eb = 0; ed = 0;
        end else begin
          v  = (j / h) % len;
          ep = (j / (len * h)) % 256;
          eb = 1;
          ed = (rp != 0 && j == total - 1) ? 1 : 0;
        end
        check_eq("word", 32'({dut_rst, dut_in}), 32'(ref_mem[v]));
        check_eq("vec", 32'(vec_idx), v);
        check_eq("pass", 32'(pass_idx), ep);
        check_eq("busy", 32'(busy), eb);
        check_eq("done", 32'(done), ed);
        if (busy && vec_idx == 1) vis1++;
      end
    end
    pause = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int dummy, v1, h, rp, len, k;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    seq_len = '0; hold = '0; reps = '0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    #1;
    check_idle_reset("rst");
    check_eq("rst_wr_err", 32'(wr_err), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: back-to-back playback, single pass
    load(0, 8'h05, 1); load(1, 8'h8A, 1); load(2, 8'h13, 1); load(3, 8'h7F, 1);
    play(4, 1, 1, 8, -1, 0, 1'b0, dummy);
    check_eq("t1_hold7f", 32'({dut_rst, dut_in}), 32'h7F);

    // 2: hold 3, two passes
    play(4, 3, 2, 28, -1, 0, 1'b0, dummy);

    // 3: infinite loop, then stop
    play(2, 1, 0, 110, -1, 0, 1'b0, dummy);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle_reset("stop");

    // 4: pause during the second cycle of vector 1
    play(4, 4, 1, 24, 6, 5, 1'b0, v1);
    check_eq("t4_v1_cycles", 32'(v1), 9);

    // 5: dropped writes leave RAM untouched
    seq_len = 6'd4; hold = 8'd1; reps = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check_eq("busy_wr_err", 32'(wr_err), 1);
    k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    check_eq("busy_fall", 32'(busy), 0);
    load(DEPTH, 8'h55, 0);
    tick();
    check_eq("wr_err_pulse", 32'(wr_err), 0);
    play(4, 1, 1, 6, -1, 0, 1'b0, dummy);

    // 6a: empty sequence
    seq_len = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("len0_done", 32'(done), 1);
    check_eq("len0_busy", 32'(busy), 0);
    check_eq("len0_word", 32'({dut_rst, dut_in}), 32'h7F);
    tick();
    check_eq("len0_done_off", 32'(done), 0);

    // 6b: start and stop together
    seq_len = 6'd4;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_idle_reset("startstop");
    tick();
    check_eq("startstop_idle", 32'(busy), 0);

    // 6c: async reset mid-pass, then replay from vector 0
    play(4, 3, 1, 5, -1, 0, 1'b0, dummy);
    rst = 1'b1;
    #2;
    check_idle_reset("async_rst");
    tick();
    rst = 1'b0;
    tick();
    play(4, 3, 1, 16, -1, 0, 1'b0, dummy);

    // randomized finite runs
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) load(a, 8'($urandom), 1);
      len = $urandom_range(1, DEPTH);
      h   = $urandom_range(0, 3);
      rp  = $urandom_range(1, 3);
      play(len, h, rp, len * ((h == 0) ? 1 : h) * rp + 3, -1, 0, 1'b0, dummy);
    end

    // randomized infinite run with random pauses, then stop
    len = $urandom_range(1, 8);
    play(len, $urandom_range(0, 2), 0, 80, -1, 0, 1'b1, dummy);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle_reset("rnd_stop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
